// File: rtl/pl_adc_packer.sv
// Packs pairs of 12-bit ADC samples into 32-bit sequence-tagged words and
// buffers them in a show-ahead FIFO for a ready/valid consumer.
//
// state | meaning
// IDLE  | waiting for i_Start; samples ignored
// RUN   | accepting samples, forming words
// FLUSH | burst count reached; draining pack register and FIFO
// DONE  | burst complete; waits for i_Start to drop

module pl_adc_packer #(
  parameter int P_BURST_LEN  = 100000,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                              i_CMOS_Clk,
  input  logic                              i_Rst_n,
  input  logic                              i_Start,
  input  logic [11:0]                       i_Sample,
  input  logic                              i_Sample_Valid,
  output logic [31:0]                       o_Word,
  output logic                              o_Word_Valid,
  input  logic                              i_Word_Ready,
  output logic                              o_Busy,
  output logic                              o_Done,
  output logic                              o_Overflow,
  output logic [$clog2(P_FIFO_DEPTH):0]     o_Fill
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam logic [19:0] BURST = P_BURST_LEN[19:0];
  localparam logic [AW:0] DEPTH = P_FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic [19:0]   sample_cnt;
  logic [7:0]    seq;
  logic          hold_v;
  logic [11:0]   hold_s;
  logic          pack_v;
  logic [31:0]   pack_word;
  logic [31:0]   mem [P_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill;
  logic          overflow;

  logic          start_burst;
  logic          accept;
  logic          last;
  logic          form;
  logic [19:0]   cnt_inc;
  logic [31:0]   word_nxt;
  logic          pop;
  logic          wr_ok;
  logic          wr;
  logic          drop;

  assign accept   = (state == RUN) && i_Sample_Valid;
  assign cnt_inc  = sample_cnt + 20'd1;
  assign last     = accept && (cnt_inc == BURST);
  // A lone final sample of an odd burst closes its word with a zero upper half.
  assign form     = accept && (hold_v || last);
  assign word_nxt = hold_v ? {seq, i_Sample, hold_s} : {seq, 12'h000, i_Sample};

  assign pop   = (fill != '0) && i_Word_Ready;
  assign wr_ok = (fill < DEPTH) || pop;
  assign wr    = pack_v && wr_ok;
  assign drop  = pack_v && !wr_ok;

  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_burst = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          state_nxt   = RUN;
          start_burst = 1'b1;
        end
      end
      RUN:     if (last) state_nxt = FLUSH;
      FLUSH:   if ((fill == '0) && !pack_v) state_nxt = DONE;
      DONE:    if (!i_Start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sample_cnt <= '0;
      seq        <= '0;
      hold_v     <= 1'b0;
      hold_s     <= '0;
      pack_v     <= 1'b0;
      pack_word  <= '0;
      overflow   <= 1'b0;
    end else begin
      pack_v <= form;
      if (drop) overflow <= 1'b1;
      if (start_burst) begin
        sample_cnt <= '0;
        seq        <= '0;
        hold_v     <= 1'b0;
        overflow   <= 1'b0;
      end else if (accept) begin
        sample_cnt <= cnt_inc;
        if (form) begin
          pack_word <= word_nxt;
          seq       <= seq + 8'd1;
          hold_v    <= 1'b0;
        end else begin
          hold_s <= i_Sample;
          hold_v <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CMOS_Clk) begin
    if (wr) mem[wr_ptr] <= pack_word;
  end

  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  assign o_Word_Valid = (fill != '0);
  assign o_Word       = o_Word_Valid ? mem[rd_ptr] : 32'h0;
  assign o_Fill       = fill;
  assign o_Overflow   = overflow;
  assign o_Busy       = (state == RUN) || (state == FLUSH);
  assign o_Done       = (state == DONE);

endmodule

// File: tb/tb_pl_adc_packer.sv
// Bench for pl_adc_packer: three instances (burst 4, burst 3, depth-4/burst-12)
// driven by vector tables, directed sequences and random traffic vs. a model.

module tb_pl_adc_packer;

  localparam int CL = 12;
  localparam int CD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        start  [3];
  logic        valid  [3];
  logic [11:0] smp    [3];
  logic        ready  [3];
  logic [31:0] word   [3];
  logic        wvalid [3];
  logic        busy   [3];
  logic        done   [3];
  logic        ovf    [3];
  logic [31:0] fillx  [3];
  logic [4:0]  fill_a, fill_b;
  logic [2:0]  fill_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pl_adc_packer #(.P_BURST_LEN(4), .P_FIFO_DEPTH(16)) dut_a (
    .i_CMOS_Clk(clk), .i_Rst_n(rst[0]), .i_Start(start[0]), .i_Sample(smp[0]),
    .i_Sample_Valid(valid[0]), .o_Word(word[0]), .o_Word_Valid(wvalid[0]),
    .i_Word_Ready(ready[0]), .o_Busy(busy[0]), .o_Done(done[0]),
    .o_Overflow(ovf[0]), .o_Fill(fill_a));

  pl_adc_packer #(.P_BURST_LEN(3), .P_FIFO_DEPTH(16)) dut_b (
    .i_CMOS_Clk(clk), .i_Rst_n(rst[1]), .i_Start(start[1]), .i_Sample(smp[1]),
    .i_Sample_Valid(valid[1]), .o_Word(word[1]), .o_Word_Valid(wvalid[1]),
    .i_Word_Ready(ready[1]), .o_Busy(busy[1]), .o_Done(done[1]),
    .o_Overflow(ovf[1]), .o_Fill(fill_b));

  pl_adc_packer #(.P_BURST_LEN(CL), .P_FIFO_DEPTH(CD)) dut_c (
    .i_CMOS_Clk(clk), .i_Rst_n(rst[2]), .i_Start(start[2]), .i_Sample(smp[2]),
    .i_Sample_Valid(valid[2]), .o_Word(word[2]), .o_Word_Valid(wvalid[2]),
    .i_Word_Ready(ready[2]), .o_Busy(busy[2]), .o_Done(done[2]),
    .o_Overflow(ovf[2]), .o_Fill(fill_c));

  assign fillx[0] = 32'(fill_a);
  assign fillx[1] = 32'(fill_b);
  assign fillx[2] = 32'(fill_c);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut_c: the burst is a list of accepted samples; word k
  // is {k, s[2k+1], s[2k]} and reaches the FIFO queue one edge after forming.
  int          m_phase  = M_IDLE;
  logic [31:0] m_q [$];
  logic [11:0] m_s [$];
  logic        m_pend_v = 1'b0;
  logic [31:0] m_pend   = 32'h0;
  logic        m_ovf    = 1'b0;

  task automatic m_step();
    bit pop, wr_ok, q_empty, pend_pre;
    int n;
    if (!rst[2]) begin
      m_phase  = M_IDLE;
      m_q.delete();
      m_s.delete();
      m_pend_v = 1'b0;
      m_ovf    = 1'b0;
      return;
    end
    q_empty  = (m_q.size() == 0);
    pend_pre = m_pend_v;
    pop      = !q_empty && ready[2];
    wr_ok    = (m_q.size() < CD) || pop;
    if (pop) void'(m_q.pop_front());
    if (m_pend_v) begin
      if (wr_ok) m_q.push_back(m_pend);
      else       m_ovf = 1'b1;
    end
    m_pend_v = 1'b0;
    case (m_phase)
      M_IDLE: if (start[2]) begin
        m_phase = M_RUN;
        m_s.delete();
        m_ovf = 1'b0;
      end
      M_RUN: if (valid[2]) begin
        m_s.push_back(smp[2]);
        n = m_s.size();
        if (n % 2 == 0) begin
          m_pend   = {8'(n / 2 - 1), m_s[n-1], m_s[n-2]};
          m_pend_v = 1'b1;
        end else if (n == CL) begin
          m_pend   = {8'(n / 2), 12'h000, m_s[n-1]};
          m_pend_v = 1'b1;
        end
        if (n == CL) m_phase = M_FLUSH;
      end
      M_FLUSH: if (q_empty && !pend_pre) m_phase = M_DONE;
      default: if (!start[2]) m_phase = M_IDLE;
    endcase
  endtask

  task automatic m_check();
    chk("c_valid", 32'(wvalid[2]), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("c_word", word[2], m_q[0]);
    chk("c_fill", fillx[2], 32'(m_q.size()));
    chk("c_ovf", 32'(ovf[2]), 32'(m_ovf));
    chk("c_busy", 32'(busy[2]), 32'((m_phase == M_RUN) || (m_phase == M_FLUSH)));
    chk("c_done", 32'(done[2]), 32'(m_phase == M_DONE));
  endtask

  always @(posedge clk) begin
    m_step();
    #1;
    m_check();
  end

  typedef struct {
    int          inst;
    logic        start, valid;
    logic [11:0] sample;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic        exp_busy, exp_done, exp_ovf;
    int          exp_fill;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(int inst, logic st, logic v, logic [11:0] s, logic r,
                              logic ev, logic [31:0] ew, logic eb, logic ed, int ef);
    vec_t x;
    x.inst = inst; x.start = st; x.valid = v; x.sample = s; x.ready = r;
    x.exp_valid = ev; x.exp_word = ew; x.exp_busy = eb; x.exp_done = ed;
    x.exp_ovf = 1'b0; x.exp_fill = ef;
    return x;
  endfunction

  task automatic c_drive(input logic st, input logic v, input logic [11:0] s, input logic r);
    start[2] = st; valid[2] = v; smp[2] = s; ready[2] = r;
    cyc();
  endtask

  logic [31:0] got [$];

  task automatic c_drain(output bit ok);
    got.delete();
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (done[2]) begin
        ok = 1'b1;
        break;
      end
      if (wvalid[2]) got.push_back(word[2]);
      c_drive(1'b1, 1'b0, 12'h0, 1'b1);
    end
  endtask

  initial begin
    logic [11:0] s1 [12];
    bit ok;
    int rp;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0; valid[i] = 1'b0; smp[i] = '0; ready[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_word",  word[i], 32'h0);
      chk("rst_valid", 32'(wvalid[i]), 32'h0);
      chk("rst_busy",  32'(busy[i]), 32'h0);
      chk("rst_done",  32'(done[i]), 32'h0);
      chk("rst_ovf",   32'(ovf[i]), 32'h0);
      chk("rst_fill",  fillx[i], 32'h0);
    end
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    cyc();

    // burst of 4, then start held through DONE, then restart
    vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 12'h001, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 12'h002, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 12'h003, 1, 1, 32'h00002001, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 12'h004, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 12'h000, 1, 1, 32'h01004003, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 12'h555, 1, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 12'h000, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 12'h777, 1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 12'h00A, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 12'h00B, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 12'h000, 0, 1, 32'h0000B00A, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 12'h000, 0, 1, 32'h0000B00A, 1, 0, 1));
    // odd burst of 3 with back-pressure
    vecs.push_back(mk(1, 1, 0, 12'h000, 0, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 12'hABC, 0, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 12'h123, 0, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 12'hFFF, 0, 1, 32'h00123ABC, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 12'h000, 0, 1, 32'h00123ABC, 1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 12'h000, 1, 1, 32'h01000FFF, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 12'h000, 1, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 12'h000, 1, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 12'h000, 1, 0, 32'h0,        0, 0, 0));

    foreach (vecs[k]) begin
      automatic int i = vecs[k].inst;
      start[i] = vecs[k].start; valid[i] = vecs[k].valid;
      smp[i] = vecs[k].sample; ready[i] = vecs[k].ready;
      cyc();
      chk($sformatf("vec%0d_valid", k), 32'(wvalid[i]), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) chk($sformatf("vec%0d_word", k), word[i], vecs[k].exp_word);
      chk($sformatf("vec%0d_busy", k), 32'(busy[i]), 32'(vecs[k].exp_busy));
      chk($sformatf("vec%0d_done", k), 32'(done[i]), 32'(vecs[k].exp_done));
      chk($sformatf("vec%0d_ovf", k), 32'(ovf[i]), 32'(vecs[k].exp_ovf));
      chk($sformatf("vec%0d_fill", k), fillx[i], 32'(vecs[k].exp_fill));
    end
    valid[0] = 1'b0;

    // overflow: depth 4, 6 words with no consumer
    foreach (s1[k]) s1[k] = 12'($urandom);
    c_drive(1, 0, 12'h0, 0);
    for (int k = 0; k < 12; k++) c_drive(1, 1, s1[k], 0);
    c_drive(1, 0, 12'h0, 0);
    chk("ovf_fill", fillx[2], 32'd4);
    chk("ovf_flag", 32'(ovf[2]), 32'd1);
    c_drain(ok);
    chk("ovf_drain_timeout", 32'(ok), 32'd1);
    chk("ovf_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) chk($sformatf("ovf_word%0d", k), got[k], {8'(k), s1[2*k+1], s1[2*k]});
    chk("ovf_sticky_done", 32'(ovf[2]), 32'd1);
    c_drive(0, 0, 12'h0, 0);
    chk("ovf_sticky_idle", 32'(ovf[2]), 32'd1);

    // full FIFO with pop and write on the same edge
    foreach (s1[k]) s1[k] = 12'($urandom);
    c_drive(1, 0, 12'h0, 0);
    chk("full_ovf_clear", 32'(ovf[2]), 32'd0);
    for (int k = 0; k < 10; k++) c_drive(1, 1, s1[k], 0);
    chk("full_fill", fillx[2], 32'd4);
    c_drive(1, 1, s1[10], 1);
    chk("full_simul_fill", fillx[2], 32'd4);
    chk("full_simul_ovf", 32'(ovf[2]), 32'd0);
    chk("full_simul_head", word[2], {8'd1, s1[3], s1[2]});
    c_drive(1, 1, s1[11], 0);
    c_drive(1, 0, 12'h0, 1);
    chk("full_simul2_fill", fillx[2], 32'd4);
    c_drain(ok);
    chk("full_drain_timeout", 32'(ok), 32'd1);
    chk("full_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got.size())
        chk($sformatf("full_word%0d", k), got[k], {8'(k + 2), s1[2*k+5], s1[2*k+4]});
    chk("full_no_ovf", 32'(ovf[2]), 32'd0);
    c_drive(0, 0, 12'h0, 0);

    // asynchronous reset in the middle of a burst
    c_drive(1, 0, 12'h0, 0);
    for (int k = 0; k < 6; k++) c_drive(1, 1, 12'($urandom), 0);
    chk("mid_fill", fillx[2], 32'd2);
    #3 rst[2] = 1'b0;
    #1;
    chk("arst_word",  word[2], 32'h0);
    chk("arst_valid", 32'(wvalid[2]), 32'h0);
    chk("arst_busy",  32'(busy[2]), 32'h0);
    chk("arst_done",  32'(done[2]), 32'h0);
    chk("arst_ovf",   32'(ovf[2]), 32'h0);
    chk("arst_fill",  fillx[2], 32'h0);
    cyc();
    rst[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c_drive(0, 1, 12'($urandom), 1);
      chk("post_rst_busy", 32'(busy[2]), 32'h0);
      chk("post_rst_fill", fillx[2], 32'h0);
    end
    c_drive(1, 0, 12'h0, 0);
    chk("post_rst_run", 32'(busy[2]), 32'h1);

    // random traffic with varying consumer speed, checked by the model
    for (int blk = 0; blk < 9; blk++) begin
      rp = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 50 : 90);
      for (int t = 0; t < 200; t++)
        c_drive($urandom_range(99) < 85, $urandom_range(3) != 0, 12'($urandom),
                $urandom_range(99) < rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
